// File: rtl/read_flash_state_control.sv
// read_flash_state_control
//   Page-read sequencer for the NAND flash controller. On a read request it
//   walks read_pages consecutive pages. For each page it checks the block
//   status and skips bad blocks, then issues the page read and waits for the
//   low-level engine to finish. It then checks ECC and retries uncorrectable
//   pages up to MAX_RETRY extra times before aborting the request.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   en_read              request level, sampled only in IDLE
//   read_pages           page count, latched when the request is accepted
//   state                low-level engine state (LL_READ_DONE = page transfer complete)
//   read_addr_row_error  block status: 1 good, 2 bad, 0/3 pending
//   ecc_status           page ECC: 1 ok, 2 uncorrectable, 0/3 pending
//   read_state           current sequencer state code
//   rd_req/addr_inc/blk_skip  single-cycle pulses to the address/command path
//   pages_done           pages read successfully in this request
//   end_read, read_fail  completion handshake, held until en_read drops
module read_flash_state_control #(
    parameter int LL_READ_DONE = 3,
    parameter int MAX_RETRY    = 2,
    parameter int PAGE_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_read,
    input  logic [PAGE_CNT_W-1:0] read_pages,
    input  logic [4:0]            state,
    input  logic [1:0]            read_addr_row_error,
    input  logic [1:0]            ecc_status,
    output logic [3:0]            read_state,
    output logic                  rd_req,
    output logic                  addr_inc,
    output logic                  blk_skip,
    output logic [PAGE_CNT_W-1:0] pages_done,
    output logic                  end_read,
    output logic                  read_fail
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_POWERUP = 4'd0,
        S_IDLE    = 4'd1,
        S_START   = 4'd2,
        S_CHK_BAD = 4'd3,
        S_ISSUE   = 4'd4,
        S_SKIP    = 4'd5,
        S_CHK_ECC = 4'd6,
        S_PAGE_OK = 4'd7,
        S_RETRY   = 4'd8,
        S_FAIL    = 4'd9,
        S_DONE    = 4'd10,
        S_RELEASE = 4'd11
    } state_t;

    state_t                state_q, nxt;
    logic                  wait_q;      // CHK_BAD has spent its settling cycle
    logic [PAGE_CNT_W-1:0] rp_q;        // latched page count
    logic [RW-1:0]         retry_q;

    assign read_state = state_q;

    always_comb begin
        nxt = state_q;
        case (state_q)
            S_POWERUP: nxt = S_IDLE;
            S_IDLE:    if (en_read) nxt = S_START;
            S_START:   nxt = (rp_q == '0) ? S_DONE : S_CHK_BAD;
            // The row address settles one cycle after entry, so the block
            // status is only trusted from the second cycle on.
            S_CHK_BAD: begin
                if (wait_q) begin
                    if (read_addr_row_error == 2'd1)      nxt = S_ISSUE;
                    else if (read_addr_row_error == 2'd2) nxt = S_SKIP;
                end
            end
            S_ISSUE:   if (state == 5'(LL_READ_DONE)) nxt = S_CHK_ECC;
            S_SKIP:    nxt = S_START;
            S_CHK_ECC: begin
                if (ecc_status == 2'd1)
                    nxt = S_PAGE_OK;
                else if (ecc_status == 2'd2)
                    nxt = (retry_q < RW'(MAX_RETRY)) ? S_RETRY : S_FAIL;
            end
            // pages_done already holds this page's count here.
            S_PAGE_OK: nxt = (pages_done == rp_q) ? S_DONE : S_START;
            S_RETRY:   nxt = S_ISSUE;
            S_FAIL:    nxt = S_DONE;
            S_DONE:    nxt = S_RELEASE;
            S_RELEASE: if (!en_read) nxt = S_IDLE;
            default:   nxt = S_POWERUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_POWERUP;
            wait_q     <= 1'b0;
            rp_q       <= '0;
            retry_q    <= '0;
            pages_done <= '0;
            rd_req     <= 1'b0;
            addr_inc   <= 1'b0;
            blk_skip   <= 1'b0;
            end_read   <= 1'b0;
            read_fail  <= 1'b0;
        end else begin
            state_q  <= nxt;
            // Pulses decode the state being entered so they line up with it.
            rd_req   <= (nxt == S_ISSUE) && (state_q != S_ISSUE);
            addr_inc <= (nxt == S_PAGE_OK);
            blk_skip <= (nxt == S_SKIP);
            wait_q   <= (state_q == S_CHK_BAD) && (nxt == S_CHK_BAD);

            if (state_q == S_IDLE && en_read) begin
                rp_q       <= read_pages;
                pages_done <= '0;
                retry_q    <= '0;
                read_fail  <= 1'b0;
            end
            if (nxt == S_PAGE_OK)
                pages_done <= pages_done + 1'b1;
            if (state_q == S_PAGE_OK)
                retry_q <= '0;
            if (state_q == S_RETRY)
                retry_q <= retry_q + 1'b1;
            if (state_q == S_FAIL)
                read_fail <= 1'b1;
            if (state_q == S_DONE)
                end_read <= 1'b1;
            if (state_q == S_RELEASE && !en_read)
                end_read <= 1'b0;
        end
    end

endmodule

// File: tb/tb_read_flash_state_control.sv
module tb_read_flash_state_control;
    localparam int MAX_RETRY = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_read;
    logic [7:0] read_pages;
    logic [4:0] ll_state;
    logic [1:0] row_err, ecc;
    logic [3:0] read_state;
    logic       rd_req, addr_inc, blk_skip, end_read, read_fail;
    logic [7:0] pages_done;

    always #5 clk = ~clk;

    read_flash_state_control dut (
        .clk(clk), .rst(rst), .en_read(en_read), .read_pages(read_pages),
        .state(ll_state), .read_addr_row_error(row_err), .ecc_status(ecc),
        .read_state(read_state), .rd_req(rd_req), .addr_inc(addr_inc),
        .blk_skip(blk_skip), .pages_done(pages_done), .end_read(end_read),
        .read_fail(read_fail)
    );

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_s(string name, string act, string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, exp);
        end
    endtask

    // ---------------- flash environment ----------------
    // Block statuses and ECC outcomes come from scripts; an exhausted script
    // answers good / ok.
    bit         blk_q[$];
    logic [1:0] ecc_q[$];
    bit         rnd_dly;
    bit         blk_act, blk_bad, ll_arm;
    int         blk_pend, ll_dly;
    logic [1:0] ecc_out;

    function automatic logic [4:0] not_done();
        logic [4:0] v;
        v = 5'($urandom_range(0, 31));
        if (v == 5'd3) v = 5'd4;
        return v;
    endfunction

    initial begin
        row_err = 2'd0; ecc = 2'd0; ll_state = 5'd0;
        blk_act = 0; ll_arm = 0; blk_pend = 0; ll_dly = 0; ecc_out = 2'd1; blk_bad = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                blk_act = 0; ll_arm = 0; row_err = 2'd0; ecc = 2'd0; ll_state = 5'd0;
            end else begin
                if (read_state == 4'd3) begin
                    if (!blk_act) begin
                        blk_act  = 1;
                        blk_pend = rnd_dly ? $urandom_range(0, 2) : 0;
                        blk_bad  = (blk_q.size() > 0) ? blk_q.pop_front() : 1'b0;
                    end
                    if (blk_pend > 0) begin
                        row_err = ($urandom % 2) ? 2'd0 : 2'd3;
                        blk_pend--;
                    end else
                        row_err = blk_bad ? 2'd2 : 2'd1;
                end else begin
                    blk_act = 0;
                    row_err = ($urandom % 2) ? 2'd0 : 2'd3;
                end
                if (rd_req) begin
                    ecc_out = (ecc_q.size() > 0) ? ecc_q.pop_front() : 2'd1;
                    ll_dly  = rnd_dly ? $urandom_range(0, 3) : 0;
                    ll_arm  = 1;
                end
                if (ll_arm && ll_dly == 0) begin
                    ll_state = 5'd3;
                    ecc      = ecc_out;
                    ll_arm   = 0;
                end else begin
                    if (ll_arm) begin
                        ll_dly--;
                        ecc = ($urandom % 2) ? 2'd0 : 2'd3;
                    end
                    ll_state = not_done();
                end
            end
        end
    end

    // ---------------- monitor / per-cycle rules ----------------
    string obs;
    int    first_rd, first_end, cur_n;
    bit    chk_on;
    logic  p_rd, p_ai, p_bs;
    bit    ok;

    initial begin
        obs = ""; first_rd = -1; first_end = -1; chk_on = 0; cur_n = 0;
        p_rd = 0; p_ai = 0; p_bs = 0;
        forever begin
            @(negedge clk);
            if (rd_req)   obs = {obs, "R"};
            if (addr_inc) obs = {obs, "A"};
            if (blk_skip) obs = {obs, "S"};
            if (rd_req && first_rd < 0)    first_rd = cyc;
            if (end_read && first_end < 0) first_end = cyc;
            if (chk_on) begin
                ok = (int'(rd_req) + int'(addr_inc) + int'(blk_skip) <= 1)
                  && !(rd_req && p_rd) && !(addr_inc && p_ai) && !(blk_skip && p_bs)
                  && (read_state <= 4'd11)
                  && !(end_read && (rd_req || addr_inc || blk_skip))
                  && (!end_read || read_state == 4'd11)
                  && (!read_fail || read_state == 4'd1 || read_state == 4'd10 || read_state == 4'd11)
                  && (read_state == 4'd1 || int'(pages_done) <= cur_n);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL cycle_rules cyc=%0d state=%0d rd/ai/bs=%b%b%b end=%b fail=%b pages=%0d limit=%0d",
                             cyc, read_state, rd_req, addr_inc, blk_skip, end_read, read_fail, pages_done, cur_n);
                end
            end
            p_rd = rd_req; p_ai = addr_inc; p_bs = blk_skip;
        end
    end

    // ---------------- reference model ----------------
    // Walks the scripts: bad blocks are skipped, each page read repeats until
    // ECC is ok, more than MAX_RETRY uncorrectable results aborts.
    function automatic void model(int n, bit bq[$], logic [1:0] eq[$],
                                  output string seq, output int pages, output bit fail);
        int bi, ei, fails;
        bi = 0; ei = 0; seq = ""; pages = 0; fail = 0;
        while (pages < n && !fail) begin
            while (bi < bq.size() && bq[bi]) begin
                seq = {seq, "S"};
                bi++;
            end
            bi++;
            fails = 0;
            forever begin
                seq = {seq, "R"};
                if (ei >= eq.size() || eq[ei] == 2'd1) begin
                    ei++;
                    break;
                end
                ei++;
                fails++;
                if (fails > MAX_RETRY) begin
                    fail = 1;
                    break;
                end
            end
            if (!fail) begin
                seq = {seq, "A"};
                pages++;
            end
        end
    endfunction

    task automatic gen_script(int n);
        int nbad, r, fails;
        blk_q.delete();
        ecc_q.delete();
        for (int p = 0; p < n; p++) begin
            nbad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            repeat (nbad) blk_q.push_back(1'b1);
            blk_q.push_back(1'b0);
            r = $urandom_range(0, 9);
            fails = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            repeat (fails) ecc_q.push_back(2'd2);
            if (fails > MAX_RETRY) break;
            ecc_q.push_back(2'd1);
        end
    endtask

    // ---------------- request driver ----------------
    task automatic run_req(int n, string exp_seq, int exp_pages, bit exp_fail,
                           int exp_lat_rd, int exp_lat_end);
        int t0, h;
        bit seen;
        @(negedge clk); #1;
        obs = ""; first_rd = -1; first_end = -1;
        cur_n = n; read_pages = n[7:0]; en_read = 1'b1; t0 = cyc;
        seen = 0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            @(negedge clk); #1;
            if (k == 2) read_pages = 8'($urandom);   // must already be latched
            if (end_read) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL end_read_timeout actual=no end_read required=end_read within 6000 cycles");
            chk_on = 0; rst = 1'b0; en_read = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            chk_on = 1;
            return;
        end
        chk("state_at_end", read_state, 11);
        chk("pages_done", pages_done, exp_pages);
        chk("read_fail", read_fail, exp_fail);
        chk_s("pulse_seq", obs, exp_seq);
        if (exp_lat_rd >= 0)  chk("lat_rd_req", first_rd - t0, exp_lat_rd);
        if (exp_lat_end >= 0) chk("lat_end_read", first_end - t0, exp_lat_end);
        h = $urandom_range(0, 3);
        repeat (h) begin
            @(negedge clk); #1;
            chk("hold_state", read_state, 11);
            chk("hold_end_read", end_read, 1);
        end
        en_read = 1'b0;
        @(negedge clk); #1;
        chk("release_end_read", end_read, 0);
        chk("release_state", read_state, 1);
        chk("release_read_fail", read_fail, exp_fail);
    endtask

    // ---------------- main sequence ----------------
    string s;
    int    p;
    bit    f;
    int    n;

    initial begin
        rst = 1'b0; en_read = 1'b0; read_pages = 8'd0; rnd_dly = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", read_state, 0);
        chk("rst_pulses", {rd_req, addr_inc, blk_skip}, 0);
        chk("rst_pages_done", pages_done, 0);
        chk("rst_end_fail", {end_read, read_fail}, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("powerup_to_idle", read_state, 1);
        chk_on = 1;

        // three good pages; rd_req 4 cycles after acceptance
        blk_q = '{0, 0, 0}; ecc_q = '{2'd1, 2'd1, 2'd1};
        model(3, blk_q, ecc_q, s, p, f);
        chk_s("model_t1", s, "RARARA");
        run_req(3, s, p, f, 4, -1);

        // bad block first, then two good pages
        blk_q = '{1, 0, 0}; ecc_q = '{2'd1, 2'd1};
        model(2, blk_q, ecc_q, s, p, f);
        chk_s("model_t2", s, "SRARA");
        run_req(2, s, p, f, -1, -1);

        // two uncorrectable then ok: retries on the same row
        blk_q = '{0}; ecc_q = '{2'd2, 2'd2, 2'd1};
        model(1, blk_q, ecc_q, s, p, f);
        chk_s("model_t3", s, "RRRA");
        run_req(1, s, p, f, 4, -1);

        // retries exhausted
        blk_q = '{0}; ecc_q = '{2'd2, 2'd2, 2'd2};
        model(1, blk_q, ecc_q, s, p, f);
        chk("model_t4_fail", f, 1);
        chk("model_t4_pages", p, 0);
        run_req(1, s, p, f, 4, -1);

        // zero pages: straight to done
        blk_q.delete(); ecc_q.delete();
        run_req(0, "", 0, 0, -1, 3);

        // reset while a page read is outstanding
        blk_q = '{0}; ecc_q = '{2'd1};
        @(negedge clk); #1;
        cur_n = 1; read_pages = 8'd1; en_read = 1'b1;
        for (int k = 0; k < 50 && read_state != 4'd4; k++) begin
            @(negedge clk); #1;
        end
        chk("reached_issue", read_state, 4);
        chk_on = 0;
        rst = 1'b0; en_read = 1'b0;
        #1;
        chk("mid_rst_state", read_state, 0);
        chk("mid_rst_pulses", {rd_req, addr_inc, blk_skip}, 0);
        chk("mid_rst_regs", {pages_done, end_read, read_fail}, 0);
        blk_q.delete(); ecc_q.delete();
        repeat (2) @(negedge clk);
        #1; obs = "";
        rst = 1'b1;
        #1;
        chk("post_rst_powerup", read_state, 0);
        @(negedge clk); #1;
        chk("post_rst_idle", read_state, 1);
        chk_s("post_rst_no_pulses", obs, "");
        chk_on = 1;

        // randomized requests with random engine/status latencies
        rnd_dly = 1;
        for (int i = 0; i < 30; i++) begin
            n = (i == 15) ? 20 : $urandom_range(0, 6);
            gen_script(n);
            model(n, blk_q, ecc_q, s, p, f);
            run_req(n, s, p, f, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
